// File: rtl/pht_ctrl.sv
// pht_ctrl -- pattern history table controller.
//
// Owns the single port of pat_tab. After reset it sweeps every entry to
// INIT_CNT. It then serves predict lookups and 2-bit saturating counter
// updates, one operation at a time.
//
// Handshake: a request is transferred on a cycle where valid and ready are
// both high. The requester holds valid and its payload stable until ready.
// ready is combinational from valid and state, is only ever high in IDLE,
// and is never high for both requesters in the same cycle.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   pred_valid/pred_addr/pred_ready predict request channel
//   pred_resp_vld                   one-cycle pulse, prediction result valid
//   pred_taken, pred_cnt            prediction result, held between pulses
//   upd_valid/upd_addr/upd_taken    update request channel
//   upd_ready                       update accepted this cycle
//   init_busy                       table sweep in progress
//   pht_wr_en/pht_wr_data/pht_addr  to pat_tab
//   pht_rd_data                     from pat_tab, one cycle after pht_addr
//   state_dbg                       current FSM state, for observation
module pht_ctrl #(
    parameter int         AW         = 14,
    parameter logic [1:0] INIT_CNT   = 2'b01,
    parameter int         STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pred_valid,
    input  logic [AW-1:0] pred_addr,
    output logic          pred_ready,
    output logic          pred_resp_vld,
    output logic          pred_taken,
    output logic [1:0]    pred_cnt,
    input  logic          upd_valid,
    input  logic [AW-1:0] upd_addr,
    input  logic          upd_taken,
    output logic          upd_ready,
    output logic          init_busy,
    output logic          pht_wr_en,
    output logic [1:0]    pht_wr_data,
    output logic [AW-1:0] pht_addr,
    input  logic [1:0]    pht_rd_data,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        P_RD = 3'd2,
        U_RD = 3'd3,
        U_WR = 3'd4
    } state_t;

    localparam int SW = $clog2(STARVE_LIM + 1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] addr_q;       // last address presented, so pht_addr holds
    logic [AW-1:0] upd_addr_q;
    logic          upd_taken_q;
    logic [1:0]    upd_cnt_q;
    logic [1:0]    cnt_next;
    logic [SW-1:0] starve_q;
    logic          starved;

    assign starved    = (starve_q == SW'(STARVE_LIM));
    assign pred_taken = pred_cnt[1];
    assign state_dbg  = state_q;

    // Saturating 2-bit counter step.
    always_comb begin
        cnt_next = upd_cnt_q;
        if (upd_taken_q) begin
            if (upd_cnt_q != 2'b11) cnt_next = upd_cnt_q + 2'b01;
        end else begin
            if (upd_cnt_q != 2'b00) cnt_next = upd_cnt_q - 2'b01;
        end
    end

    always_comb begin
        state_d     = state_q;
        pred_ready  = 1'b0;
        upd_ready   = 1'b0;
        pht_wr_en   = 1'b0;
        pht_wr_data = INIT_CNT;
        pht_addr    = addr_q;
        init_busy   = 1'b0;
        if (reset) begin
            // Reset wins over whatever the state register says this cycle:
            // nothing is written and no request is accepted.
            init_busy = 1'b1;
            pht_addr  = '0;
        end else begin
            case (state_q)
                INIT: begin
                    init_busy   = 1'b1;
                    pht_wr_en   = 1'b1;
                    pht_addr    = ptr_q;
                    pht_wr_data = INIT_CNT;
                    if (ptr_q == '1) state_d = IDLE;
                end
                IDLE: begin
                    // Predict wins unless absent or update has been starved.
                    upd_ready  = upd_valid & (~pred_valid | starved);
                    pred_ready = pred_valid & ~upd_ready;
                    if (upd_ready) begin
                        pht_addr = upd_addr;
                        state_d  = U_RD;
                    end else if (pred_ready) begin
                        pht_addr = pred_addr;
                        state_d  = P_RD;
                    end
                end
                P_RD: state_d = IDLE;
                U_RD: state_d = U_WR;
                U_WR: begin
                    pht_wr_en   = 1'b1;
                    pht_addr    = upd_addr_q;
                    pht_wr_data = cnt_next;
                    state_d     = IDLE;
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= INIT;
            ptr_q         <= '0;
            starve_q      <= '0;
            pred_resp_vld <= 1'b0;
            pred_cnt      <= 2'b00;
            addr_q        <= '0;
            upd_addr_q    <= '0;
            upd_taken_q   <= 1'b0;
            upd_cnt_q     <= 2'b00;
        end else begin
            state_q       <= state_d;
            addr_q        <= pht_addr;
            pred_resp_vld <= (state_q == P_RD);
            if (state_q == INIT) ptr_q <= ptr_q + 1'b1;
            if (state_q == P_RD) pred_cnt <= pht_rd_data;
            if (state_q == U_RD) upd_cnt_q <= pht_rd_data;
            if (state_q == IDLE) begin
                if (upd_ready) begin
                    starve_q    <= '0;
                    upd_addr_q  <= upd_addr;
                    upd_taken_q <= upd_taken;
                end else if (upd_valid && !starved) begin
                    starve_q <= starve_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pht_ctrl.sv
// Testbench for pht_ctrl with a behavioural pat_tab (AW=4, 16 entries).
module tb_pht_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          pred_valid;
  logic [AW-1:0] pred_addr;
  logic          pred_ready;
  logic          pred_resp_vld;
  logic          pred_taken;
  logic [1:0]    pred_cnt;
  logic          upd_valid;
  logic [AW-1:0] upd_addr;
  logic          upd_taken;
  logic          upd_ready;
  logic          init_busy;
  logic          pht_wr_en;
  logic [1:0]    pht_wr_data;
  logic [AW-1:0] pht_addr;
  logic [1:0]    pht_rd_data;
  logic [2:0]    state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0]    exp_q[$];     // expected prediction results
  logic [AW+1:0] wexp_q[$];    // expected {addr, data} of update writes
  logic [1:0]    cnt_m[DEPTH]; // reference counter table
  logic [1:0]    mem[DEPTH];   // pat_tab storage
  logic [1:0]    exp3[7];
  logic [1:0]    mon_e;
  logic [AW+1:0] mon_w;

  pht_ctrl #(.AW(AW), .INIT_CNT(2'b01), .STARVE_LIM(4)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_addr(pred_addr), .pred_ready(pred_ready),
    .pred_resp_vld(pred_resp_vld), .pred_taken(pred_taken), .pred_cnt(pred_cnt),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .init_busy(init_busy),
    .pht_wr_en(pht_wr_en), .pht_wr_data(pht_wr_data), .pht_addr(pht_addr),
    .pht_rd_data(pht_rd_data), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- pat_tab model ----------------
  always @(posedge clk) begin
    if (pht_wr_en) mem[pht_addr] <= pht_wr_data;
    pht_rd_data <= mem[pht_addr];
  end

  function automatic logic [1:0] sat_next(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else   return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (pht_wr_en && !init_busy) begin
        n_vec++;
        if (wexp_q.size() == 0) begin
          n_err++;
          $display("FAIL wr_unexpected: got addr=%0d data=%b, required no write", pht_addr, pht_wr_data);
        end else begin
          mon_w = wexp_q.pop_front();
          if ({pht_addr, pht_wr_data} !== mon_w) begin
            n_err++;
            $display("FAIL wr_scoreboard: got addr=%0d data=%b, required addr=%0d data=%b",
                     pht_addr, pht_wr_data, mon_w[AW+1:2], mon_w[1:0]);
          end
        end
      end
      if (pred_resp_vld) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pred_unexpected: got cnt=%b with no request outstanding", pred_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          if (pred_cnt !== mon_e || pred_taken !== mon_e[1]) begin
            n_err++;
            $display("FAIL pred_scoreboard: got cnt=%b taken=%b, required cnt=%b taken=%b",
                     pred_cnt, pred_taken, mon_e, mon_e[1]);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_predict(input logic [AW-1:0] a);
    bit got = 0;
    @(posedge clk); #1;
    pred_addr  = a;
    pred_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pred_ready) begin got = 1; break; end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL pred_grant: got no pred_ready in 50 cycles, required a grant");
    end else begin
      exp_q.push_back(cnt_m[a]);
    end
    @(posedge clk); #1;
    pred_valid = 1'b0;
  endtask

  // Returns one step after the grant edge, i.e. during U_RD.
  task automatic do_update(input logic [AW-1:0] a, input logic t);
    bit got = 0;
    logic [1:0] nv;
    @(posedge clk); #1;
    upd_addr  = a;
    upd_taken = t;
    upd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (upd_ready) begin got = 1; break; end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL upd_grant: got no upd_ready in 50 cycles, required a grant");
    end else begin
      nv = sat_next(cnt_m[a], t);
      cnt_m[a] = nv;
      wexp_q.push_back({a, nv});
    end
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({pht_wr_en, init_busy, pht_addr, pred_ready, upd_ready} !== {1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_cycle: got wr_en=%b busy=%b addr=%0d", pht_wr_en, init_busy, pht_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      n_vec++;
      if ({pht_wr_en, pht_addr, pht_wr_data, init_busy} !== {1'b1, i[AW-1:0], 2'b01, 1'b1}) begin
        n_err++;
        $display("FAIL init_sweep[%0d]: got wr_en=%b addr=%0d data=%b busy=%b, required 1 %0d 01 1",
                 i, pht_wr_en, pht_addr, pht_wr_data, init_busy, i);
      end
      if (i == 0) begin
        n_vec++;
        if ({pred_resp_vld, pred_taken, pred_cnt} !== 4'b0000) begin
          n_err++;
          $display("FAIL reset_outputs: got vld=%b taken=%b cnt=%b, required 0 0 00",
                   pred_resp_vld, pred_taken, pred_cnt);
        end
      end
    end
    @(negedge clk);
    n_vec++;
    if (init_busy !== 1'b0 || pht_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL init_done: got busy=%b wr_en=%b on cycle 17, required 0 0", init_busy, pht_wr_en);
    end
    foreach (cnt_m[i]) cnt_m[i] = 2'b01;
  endtask

  task automatic test_predict_latency;
    bit got = 0;
    @(posedge clk); #1;
    pred_addr  = 4'd5;
    pred_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pred_ready) begin got = 1; break; end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL lat_grant: got no pred_ready, required grant");
    end else begin
      exp_q.push_back(cnt_m[5]);
    end
    @(posedge clk); #1;
    pred_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (pred_resp_vld !== 1'b0) begin
      n_err++;
      $display("FAIL lat_t1: got resp_vld=%b at T+1, required 0", pred_resp_vld);
    end
    @(negedge clk);
    n_vec++;
    if ({pred_resp_vld, pred_cnt, pred_taken} !== {1'b1, 2'b01, 1'b0}) begin
      n_err++;
      $display("FAIL lat_t2: got vld=%b cnt=%b taken=%b at T+2, required 1 01 0",
               pred_resp_vld, pred_cnt, pred_taken);
    end
  endtask

  task automatic test_saturate;
    bit got;
    for (int i = 0; i < 7; i++) begin
      do_update(4'd5, (i < 3));
      got = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (pht_wr_en) begin got = 1; break; end
      end
      n_vec++;
      if (!got || pht_addr !== 4'd5 || pht_wr_data !== exp3[i]) begin
        n_err++;
        $display("FAIL saturate[%0d]: got wr=%b addr=%0d data=%b, required addr=5 data=%b",
                 i, got, pht_addr, pht_wr_data, exp3[i]);
      end
    end
  endtask

  task automatic test_starve;
    bit got;
    bit is_upd;
    logic [1:0] nv;
    @(posedge clk); #1;
    pred_addr  = 4'd3;
    pred_valid = 1'b1;
    upd_addr   = 4'd7;
    upd_taken  = 1'b1;
    upd_valid  = 1'b1;
    for (int g = 0; g < 15; g++) begin
      got = 0;
      is_upd = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (pred_ready && upd_ready) begin
          n_vec++;
          n_err++;
          $display("FAIL dual_ready: got both readies high, required at most one");
        end
        if (pred_ready || upd_ready) begin got = 1; is_upd = upd_ready; break; end
      end
      if (got && is_upd) begin
        nv = sat_next(cnt_m[7], 1'b1);
        cnt_m[7] = nv;
        wexp_q.push_back({4'd7, nv});
      end else if (got) begin
        exp_q.push_back(cnt_m[3]);
      end
      n_vec++;
      if (!got || is_upd !== ((g % 5) == 4)) begin
        n_err++;
        $display("FAIL starve_order[%0d]: got grant=%b update=%b, required update=%b",
                 g, got, is_upd, ((g % 5) == 4));
      end
    end
    @(posedge clk); #1;
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_update;
    do_update(4'd2, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (pht_wr_en !== 1'b0 || init_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_cycle: got wr_en=%b busy=%b, required 0 1", pht_wr_en, init_busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    wexp_q.delete();
    foreach (cnt_m[i]) cnt_m[i] = 2'b01;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      n_vec++;
      if ({pht_wr_en, pht_addr, pht_wr_data} !== {1'b1, i[AW-1:0], 2'b01}) begin
        n_err++;
        $display("FAIL midreset_sweep[%0d]: got wr_en=%b addr=%0d data=%b, required 1 %0d 01",
                 i, pht_wr_en, pht_addr, pht_wr_data, i);
      end
    end
    @(negedge clk);
    n_vec++;
    if (init_busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_done: got busy=%b, required 0", init_busy);
    end
    do_predict(4'd2);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit got = 0;
    do_update(4'd9, 1'b1);
    do_predict(4'd9);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (pred_resp_vld) begin got = 1; break; end
    end
    n_vec++;
    if (!got || pred_cnt !== 2'b10 || pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL upd_then_pred: got vld=%b cnt=%b taken=%b, required 1 10 1",
               got, pred_cnt, pred_taken);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (pred_resp_vld !== 1'b0 || pred_cnt !== 2'b10 || pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL pred_hold: got vld=%b cnt=%b taken=%b, required 0 10 1",
               pred_resp_vld, pred_cnt, pred_taken);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_update(4'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)));
      else
        do_predict(4'($urandom_range(0, DEPTH - 1)));
    end
    repeat (6) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0 || wexp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d preds and %0d writes outstanding, required 0 0",
               exp_q.size(), wexp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    exp3 = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    foreach (cnt_m[i]) cnt_m[i] = 2'b01;
    foreach (mem[i]) mem[i] = 2'b00;
    reset      = 1'b1;
    pred_valid = 1'b0;
    pred_addr  = '0;
    upd_valid  = 1'b0;
    upd_addr   = '0;
    upd_taken  = 1'b0;
    repeat (3) @(posedge clk);
    test_reset;
    test_predict_latency;
    test_saturate;
    test_starve;
    test_reset_mid_update;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
